// File: rtl/strace_fetch.sv
// strace_fetch: DTM-side initiator that pulls one trace line out of strace per fetch command.
// Define STRACE_FETCH_MAGIC_CHK_EN to check the magic register (0x12) before every fetch.
module strace_fetch #(
  parameter int POLL_MAX = 16,
  parameter int RESP_TMO = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_vld,
  output logic        fetch_rdy,
  output logic        req_vld,
  input  logic        req_rdy,
  output logic [1:0]  req_opt_code,
  output logic [6:0]  req_addr,
  output logic [31:0] req_data,
  input  logic        resp_vld,
  output logic        resp_rdy,
  input  logic [1:0]  resp_sta_code,
  input  logic [6:0]  resp_addr,
  input  logic [31:0] resp_data,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [2:0]  out_idx,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        done_vld,
  output logic [1:0]  done_sta
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int TW = $clog2(RESP_TMO + 1);
  localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);
  localparam logic [TW-1:0] TMO_LIM  = TW'(RESP_TMO);

  localparam logic [1:0]  OP_RD     = 2'b01;
  localparam logic [1:0]  OP_WR     = 2'b10;
  localparam logic [1:0]  STA_OK    = 2'b00;
  localparam logic [1:0]  STA_EMPTY = 2'b01;
  localparam logic [1:0]  STA_TMO   = 2'b10;
  localparam logic [1:0]  STA_ERR   = 2'b11;
  localparam logic [6:0]  A_CTRL    = 7'h10;
  localparam logic [6:0]  A_STAT    = 7'h11;
  localparam logic [6:0]  A_LINE    = 7'h20;
  localparam logic [31:0] WCR_DATA  = 32'h0000_0003;
  localparam logic [2:0]  LAST_IDX  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_SR0, S_WCR, S_POLL, S_LINE, S_OUT, S_DONE
`ifdef STRACE_FETCH_MAGIC_CHK_EN
    , S_MAGIC
`endif
  } state_t;

`ifdef STRACE_FETCH_MAGIC_CHK_EN
  localparam logic [6:0]  A_MAGIC    = 7'h12;
  localparam logic [31:0] MAGIC_WORD = 32'hBEAF_CAFE;
  localparam state_t      S_FIRST    = S_MAGIC;
`else
  localparam state_t      S_FIRST    = S_SR0;
`endif

  // A response is rejected on an error code or when it echoes a different address.
  function automatic logic resp_bad(input logic [1:0] sta_code,
                                    input logic [6:0] echo_addr,
                                    input logic [6:0] sent_addr);
    return (sta_code != STA_OK) || (echo_addr != sent_addr);
  endfunction

  state_t          state, state_n;
  logic            wait_ph, wait_n;
  logic [2:0]      idx, idx_n;
  logic [PW-1:0]   poll_cnt, poll_n;
  logic [TW-1:0]   tmo_cnt, tmo_n;
  logic [31:0]     word, word_n;
  logic [1:0]      sta, sta_n;

  logic            req_en;
  logic [1:0]      op;
  logic [6:0]      addr;
  logic [31:0]     wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_ph  <= 1'b0;
      idx      <= '0;
      poll_cnt <= '0;
      tmo_cnt  <= '0;
      word     <= '0;
      sta      <= STA_OK;
    end else begin
      state    <= state_n;
      wait_ph  <= wait_n;
      idx      <= idx_n;
      poll_cnt <= poll_n;
      tmo_cnt  <= tmo_n;
      word     <= word_n;
      sta      <= sta_n;
    end
  end

  always_comb begin
    state_n = state;
    wait_n  = wait_ph;
    idx_n   = idx;
    poll_n  = poll_cnt;
    tmo_n   = tmo_cnt;
    word_n  = word;
    sta_n   = sta;
    req_en  = 1'b0;
    op      = OP_RD;
    addr    = A_STAT;
    wdata   = '0;

    case (state)
      S_IDLE: begin
        if (fetch_vld) begin
          state_n = S_FIRST;
          wait_n  = 1'b0;
          idx_n   = '0;
        end
      end
`ifdef STRACE_FETCH_MAGIC_CHK_EN
      S_MAGIC: begin
        req_en = 1'b1;
        addr   = A_MAGIC;
      end
`endif
      S_SR0, S_POLL: req_en = 1'b1;
      S_WCR: begin
        req_en = 1'b1;
        op     = OP_WR;
        addr   = A_CTRL;
        wdata  = WCR_DATA;
      end
      S_LINE: begin
        req_en = 1'b1;
        addr   = A_LINE + {4'b0000, idx};
      end
      // The next line read waits for the consumer, so back-pressure stalls strace traffic.
      S_OUT: begin
        if (out_rdy) begin
          if (idx == LAST_IDX) begin
            state_n = S_DONE;
            sta_n   = STA_OK;
          end else begin
            idx_n   = idx + 3'd1;
            state_n = S_LINE;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Shared REQ/WAIT handshake for every request-issuing state.
    if (req_en) begin
      if (!wait_ph) begin
        if (req_rdy) begin
          wait_n = 1'b1;
          tmo_n  = '0;
        end
      end else if (resp_vld) begin
        wait_n = 1'b0;
        if (resp_bad(resp_sta_code, resp_addr, addr)) begin
          state_n = S_DONE;
          sta_n   = STA_ERR;
        end else begin
          case (state)
`ifdef STRACE_FETCH_MAGIC_CHK_EN
            S_MAGIC: begin
              if (resp_data == MAGIC_WORD) begin
                state_n = S_SR0;
              end else begin
                state_n = S_DONE;
                sta_n   = STA_ERR;
              end
            end
`endif
            S_SR0: begin
              if (resp_data[3]) begin
                state_n = S_DONE;
                sta_n   = STA_EMPTY;
              end else begin
                state_n = S_WCR;
              end
            end
            S_WCR: begin
              state_n = S_POLL;
              poll_n  = '0;
            end
            S_POLL: begin
              if (resp_data[1:0] == 2'b01) begin
                state_n = S_LINE;
                idx_n   = '0;
              end else begin
                poll_n = poll_cnt + PW'(1);
                if (poll_n == POLL_LIM) begin
                  state_n = S_DONE;
                  sta_n   = STA_TMO;
                end
              end
            end
            S_LINE: begin
              word_n  = resp_data;
              state_n = S_OUT;
            end
            default: ;
          endcase
        end
      end else begin
        tmo_n = tmo_cnt + TW'(1);
        if (tmo_n == TMO_LIM) begin
          state_n = S_DONE;
          sta_n   = STA_TMO;
          wait_n  = 1'b0;
        end
      end
    end
  end

  assign fetch_rdy    = (state == S_IDLE);
  assign req_vld      = req_en && !wait_ph;
  assign resp_rdy     = req_en && wait_ph;
  assign req_opt_code = req_vld ? op    : 2'b00;
  assign req_addr     = req_vld ? addr  : 7'h00;
  assign req_data     = req_vld ? wdata : 32'h0;
  assign out_vld      = (state == S_OUT);
  assign out_idx      = idx;
  assign out_data     = word;
  assign out_last     = out_vld && (idx == LAST_IDX);
  assign done_vld     = (state == S_DONE);
  assign done_sta     = done_vld ? sta : STA_OK;

endmodule
